lcv_mul_acc_pipe: RTL and testbench

- Parametrised, fully pipelined signed/unsigned multiply-accumulate unit.
- Successor to the fixed 16x16/33-bit DSP-inferred mul-add blocks. Adds configurable widths, an op-mode select, a persistent accumulator, optional saturation with an overflow flag, and valid/ready flow control.
- Fixed 3-stage pipeline (input reg, product reg, accumulate/output reg), mapping onto DSP48 A/B, M and P registers.
- Used by datapath engines needing back-to-back MAC with backpressure.

---
 rtl/lcv_mul_acc_pipe.sv | 158 +++++++++++++++
 tb/tb_lcv_mul_acc_pipe.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lcv_mul_acc_pipe.sv
// rtl/lcv_mul_acc_pipe.sv - 3-stage pipelined signed/unsigned multiply-accumulate with saturation and flow control
module lcv_mul_acc_pipe #(
    parameter int A_WIDTH   = 16,
    parameter int B_WIDTH   = 16,
    parameter int ACC_WIDTH = 48,
    parameter bit SATURATE  = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inp_valid,
    output logic                 inp_ready,
    input  logic [A_WIDTH-1:0]   inp_a,
    input  logic [B_WIDTH-1:0]   inp_b,
    input  logic [ACC_WIDTH-1:0] inp_c,
    input  logic [1:0]           inp_op,
    input  logic                 inp_signed,
    output logic                 outp_valid,
    input  logic                 outp_ready,
    output logic [ACC_WIDTH-1:0] outp_data,
    output logic                 outp_ovf
);

    localparam int P_WIDTH = A_WIDTH + B_WIDTH;

    typedef enum logic [1:0] {
        OP_MUL  = 2'd0,
        OP_MAC  = 2'd1,
        OP_MSUB = 2'd2,
        OP_LOAD = 2'd3
    } op_e;

    generate
        if (ACC_WIDTH < P_WIDTH) begin : g_width_check
            $error("lcv_mul_acc_pipe: ACC_WIDTH must be >= A_WIDTH + B_WIDTH");
        end
    endgenerate

    // Stage 1 registers
    logic                 s1_valid;
    logic [A_WIDTH-1:0]   s1_a;
    logic [B_WIDTH-1:0]   s1_b;
    logic [ACC_WIDTH-1:0] s1_c;
    op_e                  s1_op;
    logic                 s1_signed;

    // Stage 2 registers
    logic                 s2_valid;
    logic [P_WIDTH-1:0]   s2_p;
    logic [ACC_WIDTH-1:0] s2_c;
    op_e                  s2_op;
    logic                 s2_signed;

    // Stage 3 state
    logic [ACC_WIDTH-1:0] acc;

    logic                 stall;
    logic signed [P_WIDTH-1:0] a_wide;
    logic signed [P_WIDTH-1:0] b_wide;
    logic [P_WIDTH-1:0]   prod;
    logic [ACC_WIDTH:0]   p_ext;
    logic [ACC_WIDTH:0]   c_ext;
    logic [ACC_WIDTH:0]   acc_ext;
    logic [ACC_WIDTH:0]   r;
    logic                 ovf;
    logic [ACC_WIDTH-1:0] final_val;
    logic                 acc_we;

    // The whole pipe freezes, bubbles included, while the output beat is refused
    assign stall     = outp_valid & ~outp_ready;
    assign inp_ready = ~stall;

    // Stage 2 product: extend both operands to the full product width so the
    // low P_WIDTH bits of a plain signed multiply are right in both modes
    always_comb begin
        a_wide = signed'({{B_WIDTH{s1_signed & s1_a[A_WIDTH-1]}}, s1_a});
        b_wide = signed'({{A_WIDTH{s1_signed & s1_b[B_WIDTH-1]}}, s1_b});
        prod   = P_WIDTH'(a_wide * b_wide);
    end

    // Stage 3 arithmetic: one guard bit above ACC_WIDTH exposes overflow
    always_comb begin
        p_ext     = {{(ACC_WIDTH + 1 - P_WIDTH){s2_signed & s2_p[P_WIDTH-1]}}, s2_p};
        c_ext     = {s2_c[ACC_WIDTH-1], s2_c};
        acc_ext   = {acc[ACC_WIDTH-1], acc};
        r         = c_ext;
        acc_we    = 1'b0;
        case (s2_op)
            OP_MUL:  r = p_ext + c_ext;
            OP_MAC:  begin r = acc_ext + p_ext; acc_we = 1'b1; end
            OP_MSUB: begin r = acc_ext - p_ext; acc_we = 1'b1; end
            OP_LOAD: begin r = c_ext;           acc_we = 1'b1; end
            default: r = c_ext;
        endcase
        ovf       = r[ACC_WIDTH] ^ r[ACC_WIDTH-1];
        final_val = r[ACC_WIDTH-1:0];
        if (SATURATE && ovf) begin
            // The guard bit carries the true sign of the unclamped result
            final_val = r[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}}
                                     : {1'b0, {(ACC_WIDTH-1){1'b1}}};
        end
    end

    // Stage 1: capture the incoming beat (or a bubble) whenever the pipe moves
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid  <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s1_c      <= '0;
            s1_op     <= OP_MUL;
            s1_signed <= 1'b0;
        end else if (!stall) begin
            s1_valid  <= inp_valid;
            s1_a      <= inp_a;
            s1_b      <= inp_b;
            s1_c      <= inp_c;
            s1_op     <= op_e'(inp_op);
            s1_signed <= inp_signed;
        end
    end

    // Stage 2: register the product alongside the beat's control fields
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid  <= 1'b0;
            s2_p      <= '0;
            s2_c      <= '0;
            s2_op     <= OP_MUL;
            s2_signed <= 1'b0;
        end else if (!stall) begin
            s2_valid  <= s1_valid;
            s2_p      <= prod;
            s2_c      <= s1_c;
            s2_op     <= s1_op;
            s2_signed <= s1_signed;
        end
    end

    // Stage 3: output register and accumulator; data holds across bubbles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outp_valid <= 1'b0;
            outp_data  <= '0;
            outp_ovf   <= 1'b0;
            acc        <= '0;
        end else if (!stall) begin
            outp_valid <= s2_valid;
            if (s2_valid) begin
                outp_data <= final_val;
                outp_ovf  <= ovf;
                if (acc_we) begin
                    acc <= final_val;
                end
            end
        end
    end

endmodule

// File: tb/tb_lcv_mul_acc_pipe.sv
// tb/tb_lcv_mul_acc_pipe.sv - directed table-driven bench for lcv_mul_acc_pipe
module tb_lcv_mul_acc_pipe;

    localparam logic [1:0] MUL = 2'd0, MAC = 2'd1, MSUB = 2'd2, LOAD = 2'd3;

    logic        clk = 1'b0;
    logic        rst;
    logic        inp_valid;
    logic [15:0] inp_a;
    logic [15:0] inp_b;
    logic [47:0] inp_c;
    logic [1:0]  inp_op;
    logic        inp_signed;
    logic        outp_ready;

    logic        inp_ready,  inp_ready_w;
    logic        outp_valid, outp_valid_w;
    logic [47:0] outp_data,  outp_data_w;
    logic        outp_ovf,   outp_ovf_w;

    always #5 clk = ~clk;

    lcv_mul_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(48), .SATURATE(1'b1)) dut (
        .clk(clk), .rst(rst),
        .inp_valid(inp_valid), .inp_ready(inp_ready),
        .inp_a(inp_a), .inp_b(inp_b), .inp_c(inp_c), .inp_op(inp_op), .inp_signed(inp_signed),
        .outp_valid(outp_valid), .outp_ready(outp_ready),
        .outp_data(outp_data), .outp_ovf(outp_ovf)
    );

    lcv_mul_acc_pipe #(.A_WIDTH(16), .B_WIDTH(16), .ACC_WIDTH(48), .SATURATE(1'b0)) dut_w (
        .clk(clk), .rst(rst),
        .inp_valid(inp_valid), .inp_ready(inp_ready_w),
        .inp_a(inp_a), .inp_b(inp_b), .inp_c(inp_c), .inp_op(inp_op), .inp_signed(inp_signed),
        .outp_valid(outp_valid_w), .outp_ready(outp_ready),
        .outp_data(outp_data_w), .outp_ovf(outp_ovf_w)
    );

    typedef struct {
        logic [1:0]  op;
        logic        sgn;
        logic [15:0] a;
        logic [15:0] b;
        logic [47:0] c;
        logic [47:0] exp_s;
        logic        ovf_s;
        logic [47:0] exp_w;
        logic        ovf_w;
    } vec_t;

    vec_t vecs[17];
    vec_t sq[$];
    logic [47:0] out_d[$];
    int out_cyc[$];
    int acc_cyc[$];

    int tests = 0;
    int fails = 0;

    function automatic vec_t mk(input logic [1:0] op, input logic sgn, input logic [15:0] a,
                                input logic [15:0] b, input logic [47:0] c,
                                input logic [47:0] es, input logic os,
                                input logic [47:0] ew, input logic ow);
        vec_t v;
        v.op = op; v.sgn = sgn; v.a = a; v.b = b; v.c = c;
        v.exp_s = es; v.ovf_s = os; v.exp_w = ew; v.ovf_w = ow;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        inp_op     = v.op;
        inp_signed = v.sgn;
        inp_a      = v.a;
        inp_b      = v.b;
        inp_c      = v.c;
    endtask

    task automatic run_vec(input string name, input vec_t v);
        bit got;
        @(negedge clk);
        drive(v);
        inp_valid  = 1'b1;
        outp_ready = 1'b1;
        @(posedge clk);
        #1 inp_valid = 1'b0;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (outp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check({name, " result arrives"}, 64'(got), 64'd1);
        if (got) begin
            check({name, " data"},     64'(outp_data),   64'(v.exp_s));
            check({name, " ovf"},      64'(outp_ovf),    64'(v.ovf_s));
            check({name, " wrap data"}, 64'(outp_data_w), 64'(v.exp_w));
            check({name, " wrap ovf"},  64'(outp_ovf_w),  64'(v.ovf_w));
        end
    endtask

    task automatic stream(input int st_start, input int st_len, output int stalled);
        int bi;
        bit have_held;
        logic [47:0] held;
        bi = 0;
        have_held = 1'b0;
        held = '0;
        stalled = 0;
        out_d.delete(); out_cyc.delete(); acc_cyc.delete();
        for (int cyc = 0; cyc < 60 && out_d.size() < sq.size(); cyc++) begin
            @(negedge clk);
            outp_ready = !(cyc >= st_start && cyc < st_start + st_len);
            if (bi < sq.size()) begin
                drive(sq[bi]);
                inp_valid = 1'b1;
            end else begin
                inp_valid = 1'b0;
            end
            #1;
            if (outp_valid && !outp_ready) begin
                stalled++;
                check("stall inp_ready low", 64'(inp_ready), 64'd0);
                if (have_held) check("stall data held", 64'(outp_data), 64'(held));
                held = outp_data;
                have_held = 1'b1;
            end
            if (outp_valid && outp_ready) begin
                out_d.push_back(outp_data);
                out_cyc.push_back(cyc);
            end
            if (inp_valid && inp_ready) begin
                acc_cyc.push_back(cyc);
                bi++;
            end
        end
        inp_valid  = 1'b0;
        outp_ready = 1'b1;
        check("stream output count", 64'(out_d.size()), 64'(sq.size()));
        for (int i = 0; i < out_d.size() && i < sq.size(); i++)
            check($sformatf("stream beat %0d data", i), 64'(out_d[i]), 64'(sq[i].exp_s));
    endtask

    initial begin
        int stalled;
        bit seen;

        vecs[0]  = mk(LOAD, 0, 16'h0000, 16'h0000, 48'h0,              48'h0,              0, 48'h0,              0);
        vecs[1]  = mk(MAC,  1, 16'h0003, 16'h0004, 48'h0,              48'd12,             0, 48'd12,             0);
        vecs[2]  = mk(MAC,  1, 16'hFFFE, 16'h0005, 48'h0,              48'd2,              0, 48'd2,              0);
        vecs[3]  = mk(MUL,  1, 16'hFFFF, 16'hFFFF, 48'd10,             48'd11,             0, 48'd11,             0);
        vecs[4]  = mk(MAC,  1, 16'h0001, 16'h0001, 48'h0,              48'd3,              0, 48'd3,              0);
        vecs[5]  = mk(MUL,  0, 16'hFFFF, 16'hFFFF, 48'h0,              48'hFFFE0001,       0, 48'hFFFE0001,       0);
        vecs[6]  = mk(MUL,  1, 16'hFFFF, 16'hFFFF, 48'h0,              48'd1,              0, 48'd1,              0);
        vecs[7]  = mk(MSUB, 1, 16'h0002, 16'h0003, 48'h0,              48'hFFFF_FFFF_FFFD, 0, 48'hFFFF_FFFF_FFFD, 0);
        vecs[8]  = mk(MUL,  1, 16'h8000, 16'h8000, 48'h0,              48'h4000_0000,      0, 48'h4000_0000,      0);
        vecs[9]  = mk(MUL,  0, 16'h0002, 16'h0003, 48'hFFFF_FFFF_FFF6, 48'hFFFF_FFFF_FFFC, 0, 48'hFFFF_FFFF_FFFC, 0);
        vecs[10] = mk(LOAD, 1, 16'h0000, 16'h0000, 48'h7FFF_FFFF_FFFF, 48'h7FFF_FFFF_FFFF, 0, 48'h7FFF_FFFF_FFFF, 0);
        vecs[11] = mk(MAC,  1, 16'h0001, 16'h0001, 48'h0,              48'h7FFF_FFFF_FFFF, 1, 48'h8000_0000_0000, 1);
        vecs[12] = mk(MSUB, 1, 16'h0001, 16'h0001, 48'h0,              48'h7FFF_FFFF_FFFE, 0, 48'h7FFF_FFFF_FFFF, 1);
        vecs[13] = mk(LOAD, 0, 16'h0000, 16'h0000, 48'h8000_0000_0000, 48'h8000_0000_0000, 0, 48'h8000_0000_0000, 0);
        vecs[14] = mk(MSUB, 1, 16'h0001, 16'h0001, 48'h0,              48'h8000_0000_0000, 1, 48'h7FFF_FFFF_FFFF, 1);
        vecs[15] = mk(LOAD, 0, 16'h0000, 16'h0000, 48'h0,              48'h0,              0, 48'h0,              0);
        vecs[16] = mk(MAC,  0, 16'hFFFF, 16'hFFFF, 48'h0,              48'hFFFE0001,       0, 48'hFFFE0001,       0);

        rst = 1'b0; inp_valid = 1'b0; outp_ready = 1'b1;
        inp_a = '0; inp_b = '0; inp_c = '0; inp_op = MUL; inp_signed = 1'b0;
        repeat (2) @(negedge clk);
        check("reset outp_valid", 64'(outp_valid), 64'd0);
        check("reset outp_data",  64'(outp_data),  64'd0);
        check("reset outp_ovf",   64'(outp_ovf),   64'd0);
        rst = 1'b1;
        #1 check("inp_ready after reset", 64'(inp_ready), 64'd1);

        // back-to-back LOAD, MAC, MAC
        sq.delete();
        sq.push_back(mk(LOAD, 1, 16'h0000, 16'h0000, 48'h0, 48'h0,  0, 48'h0,  0));
        sq.push_back(mk(MAC,  1, 16'h0003, 16'h0004, 48'h0, 48'd12, 0, 48'd12, 0));
        sq.push_back(mk(MAC,  1, 16'hFFFE, 16'h0005, 48'h0, 48'd2,  0, 48'd2,  0));
        stream(100, 0, stalled);
        if (out_cyc.size() == 3 && acc_cyc.size() == 3) begin
            check("b2b latency",          64'(out_cyc[0] - acc_cyc[0]), 64'd3);
            check("b2b consecutive 1->2", 64'(out_cyc[1] - out_cyc[0]), 64'd1);
            check("b2b consecutive 2->3", 64'(out_cyc[2] - out_cyc[1]), 64'd1);
        end else begin
            check("b2b handshake count", 64'(out_cyc.size()), 64'd3);
        end

        for (int i = 0; i < 17; i++)
            run_vec($sformatf("vec%0d", i), vecs[i]);

        // four beats with a five-cycle output stall
        sq.delete();
        sq.push_back(mk(LOAD, 1, 16'h0000, 16'h0000, 48'd5, 48'd5,  0, 48'd5,  0));
        sq.push_back(mk(MAC,  1, 16'h0001, 16'h0002, 48'h0, 48'd7,  0, 48'd7,  0));
        sq.push_back(mk(MAC,  1, 16'h0002, 16'h0002, 48'h0, 48'd11, 0, 48'd11, 0));
        sq.push_back(mk(MSUB, 1, 16'h0001, 16'h0001, 48'h0, 48'd10, 0, 48'd10, 0));
        stream(3, 5, stalled);
        check("stall cycle count", 64'(stalled), 64'd5);
        run_vec("post-stall mac", mk(MAC, 1, 16'h0001, 16'h0001, 48'h0, 48'd11, 0, 48'd11, 0));

        // reset with two beats in flight
        @(negedge clk);
        drive(mk(MAC, 1, 16'h0001, 16'h0001, 48'h0, 48'h0, 0, 48'h0, 0));
        inp_valid = 1'b1;
        @(negedge clk);
        @(negedge clk);
        inp_valid = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (outp_valid) begin
                seen = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("in-flight beat reaches output", 64'(seen), 64'd1);
        rst = 1'b0;
        #1;
        check("async reset outp_valid", 64'(outp_valid), 64'd0);
        check("async reset outp_data",  64'(outp_data),  64'd0);
        @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            if (outp_valid) seen = 1'b1;
        end
        check("no beat survives reset", 64'(seen), 64'd0);
        run_vec("mac after reset", mk(MAC, 1, 16'h0002, 16'h0003, 48'h0, 48'd6, 0, 48'd6, 0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
